// File: rtl/seq_code_ctrl.sv
// rtl/seq_code_ctrl.sv - run controller for the 5-code sequence counter
// Steps the code register N positions forward or reverse with pause, abort and idle preload.
module seq_code_ctrl #(
    parameter int         STEP_W   = 8,
    parameter logic [2:0] RST_CODE = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              dir,
    input  logic              pause,
    input  logic              abort,
    input  logic              load,
    input  logic [2:0]        load_code,
    output logic [2:0]        code,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left,
    output logic              load_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_code;
    logic [STEP_W-1:0] r_steps;
    logic              r_dir;
    logic              r_load_err;

    state_t            w_state_nxt;
    logic [2:0]        w_code_nxt;
    logic [STEP_W-1:0] w_steps_nxt;
    logic              w_dir_nxt;
    logic              w_load_err_nxt;

    function automatic logic f_legal(input logic [2:0] c);
        case (c)
            3'b000, 3'b100, 3'b111, 3'b010, 3'b011: f_legal = 1'b1;
            default:                                f_legal = 1'b0;
        endcase
    endfunction

    // Illegal codes fall back to 100 so the counter re-enters the ring in either direction.
    function automatic logic [2:0] f_next(input logic [2:0] c, input logic rev);
        logic [2:0] n;
        n = 3'b100;
        if (!rev) begin
            case (c)
                3'b000:  n = 3'b100;
                3'b100:  n = 3'b111;
                3'b111:  n = 3'b010;
                3'b010:  n = 3'b011;
                3'b011:  n = 3'b000;
                default: n = 3'b100;
            endcase
        end else begin
            case (c)
                3'b000:  n = 3'b011;
                3'b011:  n = 3'b010;
                3'b010:  n = 3'b111;
                3'b111:  n = 3'b100;
                3'b100:  n = 3'b000;
                default: n = 3'b100;
            endcase
        end
        return n;
    endfunction

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_steps_nxt    = r_steps;
        w_dir_nxt      = r_dir;
        w_load_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dir_nxt   = dir;
                    w_steps_nxt = num_steps;
                    if (num_steps != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if (load) begin
                    if (f_legal(load_code)) begin
                        w_code_nxt = load_code;
                    end else begin
                        w_load_err_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_steps_nxt = '0;
                end else if (pause) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_code_nxt = f_next(r_code, r_dir);
                    if (r_steps != '0) begin
                        w_steps_nxt = r_steps - 1'b1;
                    end
                    if (r_steps <= 1) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_HOLD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_steps_nxt = '0;
                end else if (!pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_code     <= RST_CODE;
            r_steps    <= '0;
            r_dir      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_steps    <= w_steps_nxt;
            r_dir      <= w_dir_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign code       = r_code;
    assign busy       = (r_state == S_RUN) || (r_state == S_HOLD);
    assign done       = (r_state == S_DONE);
    assign steps_left = r_steps;
    assign load_err   = r_load_err;

endmodule
